// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - op codes, decode types and width helper for serial_alu_w
package serial_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADC = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_MOV = 4'b0111;
    localparam logic [3:0] OP_CMP = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1100;
    localparam logic [3:0] OP_RCL = 4'b1110;

    localparam int OPB_SUB    = 0;
    localparam int OPB_WCARRY = 1;

    typedef enum logic [2:0] {K_ADD, K_AND, K_OR, K_XOR, K_MOV, K_SHL} alu_kind_e;
    typedef enum logic {S_IDLE, S_RUN} alu_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_alu_digit.sv
// rtl/serial_alu_digit.sv - combinational per-digit datapath: extension, adder, logic ops, shift
module serial_alu_digit
    import serial_alu_pkg::*;
#(
    parameter int NSHIFT = 2
) (
    input  logic [NSHIFT-1:0] arg1,
    input  logic [NSHIFT-1:0] arg2,
    input  alu_kind_e         kind,
    input  logic              sub,
    input  logic              carry_in,
    input  logic              ext_en,
    input  logic              ext_bit,
    input  logic              shift_in,
    output logic [NSHIFT-1:0] result,
    output logic              carry_out,
    output logic              overflow
);

    logic [NSHIFT-1:0] b;
    logic [NSHIFT:0]   sum;
    logic [NSHIFT:0]   shl;

    always_comb begin
        b = ext_en ? {NSHIFT{ext_bit}} : arg2;
        if (sub) b = ~b;
        sum = {1'b0, arg1} + {1'b0, b} + {{NSHIFT{1'b0}}, carry_in};
        shl = {arg1, shift_in};
        // carry into the MSB differs from carry out of it exactly on signed overflow
        overflow  = arg1[NSHIFT-1] ^ b[NSHIFT-1] ^ sum[NSHIFT-1] ^ sum[NSHIFT];
        result    = sum[NSHIFT-1:0];
        carry_out = sum[NSHIFT];
        case (kind)
            K_AND: result = arg1 & b;
            K_OR:  result = arg1 | b;
            K_XOR: result = arg1 ^ b;
            K_MOV: result = b;
            K_SHL: begin
                result    = shl[NSHIFT-1:0];
                carry_out = shl[NSHIFT];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_alu_w.sv
// rtl/serial_alu_w.sv - multi-register bit-serial ALU top; SERIAL_ALU_SHIFT_EN enables SHL/RCL
module serial_alu_w
    import serial_alu_pkg::*;
#(
    parameter  int NSHIFT         = 2,
    parameter  int REG_BITS       = 8,
    parameter  int MAX_REGS       = 4,
    parameter  int OP_BITS        = 4,
    localparam int DIGITS_PER_REG = REG_BITS / NSHIFT,
    localparam int CNT_BITS       = (clog2(MAX_REGS * DIGITS_PER_REG) > 1) ? clog2(MAX_REGS * DIGITS_PER_REG) : 1,
    localparam int LEN_BITS       = (clog2(MAX_REGS) > 1) ? clog2(MAX_REGS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic                start_ready,
    input  logic [OP_BITS-1:0]  operation,
    input  logic [LEN_BITS-1:0] op_len,
    input  logic [LEN_BITS-1:0] arg2_len,
    input  logic                sext2,
    input  logic                update_carry_flags,
    input  logic                update_other_flags,
    input  logic                step,
    input  logic [NSHIFT-1:0]   arg1_in,
    input  logic [NSHIFT-1:0]   arg2_in,
    output logic [NSHIFT-1:0]   result_out,
    output logic                result_valid,
    output logic                busy,
    output logic                op_done,
    output logic [CNT_BITS-1:0] counter,
    output logic                flag_c,
    output logic                flag_v,
    output logic                flag_s,
    output logic                flag_z
);

    alu_state_e          state_q, state_d;
    logic [CNT_BITS-1:0] counter_q, counter_d;
    logic [LEN_BITS-1:0] op_len_q, op_len_d, arg2_len_q, arg2_len_d;
    alu_kind_e           kind_q, kind_d;
    logic                sext2_q, sext2_d, sub_q, sub_d, arith_q, arith_d, wb_q, wb_d;
    logic                upd_c_q, upd_c_d, upd_o_q, upd_o_d;
    logic                carry_q, carry_d, sign2_q, sign2_d, nz_q, nz_d;
    logic                flag_c_q, flag_c_d, flag_v_q, flag_v_d;
    logic                flag_s_q, flag_s_d, flag_z_q, flag_z_d;
    logic                shift_bit;
`ifdef SERIAL_ALU_SHIFT_EN
    logic                shift_q, shift_d;
    assign shift_bit = shift_q;
`else
    assign shift_bit = 1'b0;
`endif

    logic [31:0]         op_w;
    alu_kind_e           dec_kind;
    logic                dec_arith, dec_sub, dec_wb, dec_ok;
    logic [CNT_BITS-1:0] last_idx;
    int                  a2_end;
    logic                step_act, ext_en;
    logic [NSHIFT-1:0]   dres;
    logic                dcarry, dovf;

    assign busy         = (state_q == S_RUN);
    assign step_act     = busy && step;
    assign last_idx     = CNT_BITS'((int'(op_len_q) + 1) * DIGITS_PER_REG - 1);
    assign a2_end       = (int'(arg2_len_q) + 1) * DIGITS_PER_REG;
    assign ext_en       = int'(counter_q) >= a2_end;
    assign op_done      = step_act && (counter_q == last_idx);
    assign start_ready  = !busy || op_done;
    assign result_out   = step_act ? dres : '0;
    assign result_valid = step_act && wb_q;
    assign counter      = counter_q;
    assign flag_c       = flag_c_q;
    assign flag_v       = flag_v_q;
    assign flag_s       = flag_s_q;
    assign flag_z       = flag_z_q;

    serial_alu_digit #(.NSHIFT(NSHIFT)) u_digit (
        .arg1      (arg1_in),
        .arg2      (arg2_in),
        .kind      (kind_q),
        .sub       (sub_q),
        .carry_in  (carry_q),
        .ext_en    (ext_en),
        .ext_bit   (sign2_q && sext2_q),
        .shift_in  (shift_bit),
        .result    (dres),
        .carry_out (dcarry),
        .overflow  (dovf)
    );

    // Unknown codes behave as MOV but are barred from touching any flag.
    always_comb begin
        op_w      = 32'(operation);
        dec_kind  = K_MOV;
        dec_arith = 1'b0;
        dec_wb    = 1'b1;
        dec_ok    = 1'b1;
        case (op_w)
            32'(OP_ADD), 32'(OP_SUB), 32'(OP_ADC), 32'(OP_SBC): begin
                dec_kind  = K_ADD;
                dec_arith = 1'b1;
            end
            32'(OP_CMP): begin
                dec_kind  = K_ADD;
                dec_arith = 1'b1;
                dec_wb    = 1'b0;
            end
            32'(OP_AND): dec_kind = K_AND;
            32'(OP_OR):  dec_kind = K_OR;
            32'(OP_XOR): dec_kind = K_XOR;
            32'(OP_MOV): dec_kind = K_MOV;
`ifdef SERIAL_ALU_SHIFT_EN
            32'(OP_SHL), 32'(OP_RCL): dec_kind = K_SHL;
`endif
            default: dec_ok = 1'b0;
        endcase
        dec_sub = dec_arith && op_w[OPB_SUB];
    end

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        op_len_d   = op_len_q;
        arg2_len_d = arg2_len_q;
        kind_d     = kind_q;
        sext2_d    = sext2_q;
        sub_d      = sub_q;
        arith_d    = arith_q;
        wb_d       = wb_q;
        upd_c_d    = upd_c_q;
        upd_o_d    = upd_o_q;
        carry_d    = carry_q;
        sign2_d    = sign2_q;
        nz_d       = nz_q;
        flag_c_d   = flag_c_q;
        flag_v_d   = flag_v_q;
        flag_s_d   = flag_s_q;
        flag_z_d   = flag_z_q;
`ifdef SERIAL_ALU_SHIFT_EN
        shift_d    = shift_q;
`endif

        if (step_act) begin
            counter_d = counter_q + CNT_BITS'(1);
            nz_d      = nz_q || (|dres);
            if (arith_q) carry_d = dcarry;
`ifdef SERIAL_ALU_SHIFT_EN
            if (kind_q == K_SHL) shift_d = dcarry;
`endif
            if (int'(counter_q) == a2_end - 1) sign2_d = arg2_in[NSHIFT-1];
        end

        if (op_done) begin
            state_d   = S_IDLE;
            counter_d = '0;
            if (upd_c_q && arith_q) begin
                flag_c_d = dcarry;
                flag_v_d = dovf;
            end
            if (upd_c_q && kind_q == K_SHL) flag_c_d = dcarry;
            if (upd_o_q) begin
                flag_s_d = dres[NSHIFT-1];
                flag_z_d = !(nz_q || (|dres));
            end
        end

        // Carry-with ops seed from flag_c_d so a back-to-back ADC sees the C just committed.
        if (start && start_ready) begin
            state_d    = S_RUN;
            counter_d  = '0;
            op_len_d   = op_len;
            arg2_len_d = (arg2_len > op_len) ? op_len : arg2_len;
            kind_d     = dec_kind;
            sext2_d    = sext2;
            sub_d      = dec_sub;
            arith_d    = dec_arith;
            wb_d       = dec_wb;
            upd_c_d    = update_carry_flags && dec_ok;
            upd_o_d    = update_other_flags && dec_ok;
            carry_d    = dec_arith && (op_w[OPB_WCARRY] ? flag_c_d : dec_sub);
            sign2_d    = 1'b0;
            nz_d       = 1'b0;
`ifdef SERIAL_ALU_SHIFT_EN
            shift_d    = (dec_kind == K_SHL) && op_w[OPB_WCARRY] && flag_c_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            counter_q  <= '0;
            op_len_q   <= '0;
            arg2_len_q <= '0;
            kind_q     <= K_MOV;
            sext2_q    <= 1'b0;
            sub_q      <= 1'b0;
            arith_q    <= 1'b0;
            wb_q       <= 1'b0;
            upd_c_q    <= 1'b0;
            upd_o_q    <= 1'b0;
            carry_q    <= 1'b0;
            sign2_q    <= 1'b0;
            nz_q       <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_v_q   <= 1'b0;
            flag_s_q   <= 1'b0;
            flag_z_q   <= 1'b0;
`ifdef SERIAL_ALU_SHIFT_EN
            shift_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            op_len_q   <= op_len_d;
            arg2_len_q <= arg2_len_d;
            kind_q     <= kind_d;
            sext2_q    <= sext2_d;
            sub_q      <= sub_d;
            arith_q    <= arith_d;
            wb_q       <= wb_d;
            upd_c_q    <= upd_c_d;
            upd_o_q    <= upd_o_d;
            carry_q    <= carry_d;
            sign2_q    <= sign2_d;
            nz_q       <= nz_d;
            flag_c_q   <= flag_c_d;
            flag_v_q   <= flag_v_d;
            flag_s_q   <= flag_s_d;
            flag_z_q   <= flag_z_d;
`ifdef SERIAL_ALU_SHIFT_EN
            shift_q    <= shift_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_alu_w.sv
// tb/tb_serial_alu_w.sv - directed self-checking bench for serial_alu_w (honours SERIAL_ALU_SHIFT_EN)
module tb_serial_alu_w;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       start_ready;
    logic [3:0] operation;
    logic [1:0] op_len;
    logic [1:0] arg2_len;
    logic       sext2;
    logic       update_carry_flags;
    logic       update_other_flags;
    logic       step;
    logic [1:0] arg1_in;
    logic [1:0] arg2_in;
    logic [1:0] result_out;
    logic       result_valid;
    logic       busy;
    logic       op_done;
    logic [3:0] counter;
    logic       flag_c, flag_v, flag_s, flag_z;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_alu_w #(.NSHIFT(2), .REG_BITS(8), .MAX_REGS(4), .OP_BITS(4)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .start_ready        (start_ready),
        .operation          (operation),
        .op_len             (op_len),
        .arg2_len           (arg2_len),
        .sext2              (sext2),
        .update_carry_flags (update_carry_flags),
        .update_other_flags (update_other_flags),
        .step               (step),
        .arg1_in            (arg1_in),
        .arg2_in            (arg2_in),
        .result_out         (result_out),
        .result_valid       (result_valid),
        .busy               (busy),
        .op_done            (op_done),
        .counter            (counter),
        .flag_c             (flag_c),
        .flag_v             (flag_v),
        .flag_s             (flag_s),
        .flag_z             (flag_z)
    );

    // Tasks start and end just after a falling edge.
    task automatic start_op(input logic [3:0] op, input logic [1:0] len, input logic [1:0] a2len,
                            input logic sx, input logic step_too);
        start = 1'b1; operation = op; op_len = len; arg2_len = a2len; sext2 = sx;
        update_carry_flags = 1'b1; update_other_flags = 1'b1;
        step = step_too; arg1_in = 2'b11; arg2_in = 2'b11;
        @(negedge clk);
        start = 1'b0; step = 1'b0;
    endtask

    // stall: 0 continuous, 1 pattern 1,0,0,1,..., 2 same with a rejected start poked in the gaps
    task automatic run_digits(input logic [31:0] a1, input logic [31:0] a2, input int ndig,
                              input int stall, output logic [31:0] res, output int ndone,
                              output int nvalid, output int done_at);
        res = '0; ndone = 0; nvalid = 0; done_at = -1;
        for (int i = 0; i < ndig; i++) begin
            if (stall != 0 && (i % 2) == 1) begin
                step = 1'b0;
                if (stall == 2) begin
                    start = 1'b1; operation = 4'b0001; op_len = 2'd0;
                end
                repeat (2) @(negedge clk);
                start = 1'b0;
            end
            step = 1'b1;
            arg1_in = a1[i*2 +: 2];
            arg2_in = a2[i*2 +: 2];
            #1;
            res[i*2 +: 2] = result_out;
            if (op_done) begin ndone++; done_at = i; end
            if (result_valid) nvalid++;
            @(negedge clk);
        end
        step = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; step = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (op_done !== 1'b0) begin n_bad++; $display("FAIL reset_op_done: got %b want 0", op_done); end
        n_cmp++; if (start_ready !== 1'b1) begin n_bad++; $display("FAIL reset_start_ready: got %b want 1", start_ready); end
        n_cmp++; if (counter !== 4'd0) begin n_bad++; $display("FAIL reset_counter: got %0d want 0", counter); end
        n_cmp++; if ({result_out, result_valid} !== 3'b000) begin n_bad++; $display("FAIL reset_result: got %b want 000", {result_out, result_valid}); end
        n_cmp++; if ({flag_c, flag_v, flag_s, flag_z} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {flag_c, flag_v, flag_s, flag_z}); end
        step = 1'b0; reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [31:0] res; int nd, nv, da;
        start_op(4'b0000, 2'd1, 2'd1, 1'b0, 1'b1);
        n_cmp++; if ({busy, counter} !== 5'b1_0000) begin n_bad++; $display("FAIL add_start_idle_step: got busy/counter %b want 10000", {busy, counter}); end
        run_digits(32'h00FF, 32'h0001, 8, 0, res, nd, nv, da);
        n_cmp++; if (res[15:0] !== 16'h0100) begin n_bad++; $display("FAIL add_result: got %h want 0100", res[15:0]); end
        n_cmp++; if (nd !== 1 || da !== 7) begin n_bad++; $display("FAIL add_op_done: got count %0d at %0d want 1 at 7", nd, da); end
        n_cmp++; if (nv !== 8) begin n_bad++; $display("FAIL add_valid: got %0d want 8", nv); end
        n_cmp++; if ({busy, flag_c, flag_v, flag_s, flag_z} !== 5'b0_0000) begin n_bad++; $display("FAIL add_flags: got busy,cvsz %b want 00000", {busy, flag_c, flag_v, flag_s, flag_z}); end
    endtask

    task automatic test_sub_cmp();
        logic [31:0] res; int nd, nv, da;
        start_op(4'b0001, 2'd0, 2'd0, 1'b0, 1'b0);
        run_digits(32'h00, 32'h01, 4, 0, res, nd, nv, da);
        n_cmp++; if (res[7:0] !== 8'hFF) begin n_bad++; $display("FAIL sub_result: got %h want ff", res[7:0]); end
        n_cmp++; if ({flag_c, flag_v, flag_s, flag_z} !== 4'b0010) begin n_bad++; $display("FAIL sub_flags: got cvsz %b want 0010", {flag_c, flag_v, flag_s, flag_z}); end
        start_op(4'b1001, 2'd0, 2'd0, 1'b0, 1'b0);
        run_digits(32'h80, 32'h01, 4, 0, res, nd, nv, da);
        n_cmp++; if (nv !== 0 || nd !== 1) begin n_bad++; $display("FAIL cmp_valid: got valid %0d done %0d want 0 and 1", nv, nd); end
        n_cmp++; if ({flag_c, flag_v, flag_s, flag_z} !== 4'b1100) begin n_bad++; $display("FAIL cmp_flags: got cvsz %b want 1100", {flag_c, flag_v, flag_s, flag_z}); end
    endtask

    task automatic test_midop_reset();
        logic [31:0] res; int nd, nv, da;
        start_op(4'b0000, 2'd1, 2'd1, 1'b0, 1'b0);
        run_digits(32'h1111, 32'h2222, 3, 0, res, nd, nv, da);
        n_cmp++; if (counter !== 4'd3) begin n_bad++; $display("FAIL midrst_counter: got %0d want 3", counter); end
        step = 1'b1; reset_n = 1'b0;
        #1;
        n_cmp++; if ({busy, op_done, counter} !== 6'b00_0000) begin n_bad++; $display("FAIL midrst_state: got busy,done,counter %b want 000000", {busy, op_done, counter}); end
        n_cmp++; if ({flag_c, flag_v, flag_s, flag_z} !== 4'b0000) begin n_bad++; $display("FAIL midrst_flags: got cvsz %b want 0000", {flag_c, flag_v, flag_s, flag_z}); end
        @(negedge clk);
        step = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        start_op(4'b0001, 2'd0, 2'd0, 1'b0, 1'b0);
        run_digits(32'h00, 32'h01, 4, 0, res, nd, nv, da);
        n_cmp++; if ({res[7:0], flag_c, flag_v, flag_s, flag_z} !== {8'hFF, 4'b0010}) begin n_bad++; $display("FAIL midrst_next: got %h cvsz %b want ff 0010", res[7:0], {flag_c, flag_v, flag_s, flag_z}); end
    endtask

    task automatic test_extension();
        logic [31:0] res; int nd, nv, da;
        start_op(4'b0000, 2'd1, 2'd0, 1'b1, 1'b0);
        run_digits(32'h1234, 32'hA5FF, 8, 0, res, nd, nv, da);
        n_cmp++; if (res[15:0] !== 16'h1233 || flag_c !== 1'b1) begin n_bad++; $display("FAIL ext_sign: got %h c=%b want 1233 c=1", res[15:0], flag_c); end
        start_op(4'b0000, 2'd1, 2'd0, 1'b0, 1'b0);
        run_digits(32'h1234, 32'hA5FF, 8, 0, res, nd, nv, da);
        n_cmp++; if (res[15:0] !== 16'h1333 || flag_c !== 1'b0) begin n_bad++; $display("FAIL ext_zero: got %h c=%b want 1333 c=0", res[15:0], flag_c); end
    endtask

    task automatic test_stall_back_to_back();
        logic [31:0] res; int nd, nv, da;
        start_op(4'b0000, 2'd1, 2'd1, 1'b0, 1'b0);
        run_digits(32'h1234, 32'h4321, 8, 2, res, nd, nv, da);
        n_cmp++; if (res[15:0] !== 16'h5555 || nd !== 1) begin n_bad++; $display("FAIL stall_result: got %h done %0d want 5555 done 1", res[15:0], nd); end
        start_op(4'b0000, 2'd0, 2'd0, 1'b0, 1'b0);
        run_digits(32'hFF, 32'h01, 3, 0, res, nd, nv, da);
        step = 1'b1; arg1_in = 2'b11; arg2_in = 2'b00;
        start = 1'b1; operation = 4'b0010; op_len = 2'd0; arg2_len = 2'd0;
        #1;
        res[7:6] = result_out;
        n_cmp++; if ({op_done, start_ready} !== 2'b11) begin n_bad++; $display("FAIL b2b_done: got done,ready %b want 11", {op_done, start_ready}); end
        @(negedge clk);
        start = 1'b0; step = 1'b0;
        n_cmp++; if (res[7:0] !== 8'h00 || {flag_c, flag_z} !== 2'b11) begin n_bad++; $display("FAIL b2b_first: got %h cz %b want 00 11", res[7:0], {flag_c, flag_z}); end
        n_cmp++; if ({busy, counter} !== 5'b1_0000) begin n_bad++; $display("FAIL b2b_no_bubble: got busy,counter %b want 10000", {busy, counter}); end
        run_digits(32'h10, 32'h20, 4, 0, res, nd, nv, da);
        n_cmp++; if (res[7:0] !== 8'h31) begin n_bad++; $display("FAIL b2b_adc: got %h want 31", res[7:0]); end
    endtask

    task automatic test_shift();
        logic [31:0] res; int nd, nv, da;
        start_op(4'b0001, 2'd0, 2'd0, 1'b0, 1'b0);
        run_digits(32'h00, 32'h01, 4, 0, res, nd, nv, da);
        start_op(4'b1100, 2'd0, 2'd0, 1'b0, 1'b0);
        run_digits(32'h81, 32'h81, 4, 0, res, nd, nv, da);
`ifdef SERIAL_ALU_SHIFT_EN
        n_cmp++; if (res[7:0] !== 8'h02 || {flag_c, flag_v, flag_s, flag_z} !== 4'b1000) begin n_bad++; $display("FAIL shl: got %h cvsz %b want 02 1000", res[7:0], {flag_c, flag_v, flag_s, flag_z}); end
        start_op(4'b1110, 2'd0, 2'd0, 1'b0, 1'b0);
        run_digits(32'h00, 32'h00, 4, 0, res, nd, nv, da);
        n_cmp++; if (res[7:0] !== 8'h01 || flag_c !== 1'b0) begin n_bad++; $display("FAIL rcl: got %h c=%b want 01 c=0", res[7:0], flag_c); end
`else
        n_cmp++; if (res[7:0] !== 8'h81 || {flag_c, flag_v, flag_s, flag_z} !== 4'b0010) begin n_bad++; $display("FAIL shl_reserved: got %h cvsz %b want 81 0010", res[7:0], {flag_c, flag_v, flag_s, flag_z}); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; operation = 4'd0; op_len = 2'd0; arg2_len = 2'd0;
        sext2 = 1'b0; update_carry_flags = 1'b0; update_other_flags = 1'b0;
        step = 1'b0; arg1_in = 2'd0; arg2_in = 2'd0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub_cmp();
        test_midop_reset();
        test_extension();
        test_stall_back_to_back();
        test_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
